divisao_sequencial: RTL and testbench
=====================================

DIVISAO_SEQUENCIAL -- requirements
Module: divisao_sequencial

Interface
REQ-001 Parameter LARGURA_A, default 8, SHALL set the dividend and quotient width (legal 2..32).
REQ-002 Parameter LARGURA_B, default 4, SHALL set the divisor and remainder width (legal 1..LARGURA_A).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be the request pulse; sampled only in state OCIOSO.
REQ-006 a  input  LARGURA_A  SHALL be the unsigned dividend, captured at the accepted start edge.
REQ-007 b  input  LARGURA_B  SHALL be the unsigned divisor, captured at the accepted start edge.
REQ-008 busy  output  1  SHALL be high whenever state is not OCIOSO.
REQ-009 done  output  1  SHALL be a one-cycle completion pulse.
REQ-010 quociente  output  LARGURA_A  SHALL be the registered quotient.
REQ-011 resto  output  LARGURA_B  SHALL be the registered remainder.
REQ-012 div_zero  output  1  SHALL flag that the last completed operation had b = 0.

Function
REQ-013 FSM SHALL have exactly three states: OCIOSO, CALCULA, FIM.
REQ-014 OCIOSO + start=1 + b!=0 SHALL load a, b, clear partial remainder, load counter = LARGURA_A, go to CALCULA.
REQ-015 OCIOSO + start=1 + b=0 SHALL go directly to FIM with quociente=0, resto=0, div_zero=1 registered at that edge.
REQ-016 CALCULA SHALL perform one restoring-division step per cycle: shift partial remainder left with next dividend MSB, subtract b if not negative, shift result bit into quotient, decrement counter.
REQ-017 Partial remainder datapath SHALL be LARGURA_B+1 bits wide so the trial subtraction never overflows.
REQ-018 On the edge completing the LARGURA_A-th step, quociente, resto SHALL update, div_zero SHALL clear, state SHALL go to FIM.
REQ-019 Latency: done SHALL be high in the cycle exactly LARGURA_A cycles after the accepted start edge (1 cycle for b=0).
REQ-020 FIM SHALL assert done for one cycle and return unconditionally to OCIOSO on the next edge.
REQ-021 start while in CALCULA or FIM SHALL be ignored; no queuing.
REQ-022 start held high continuously SHALL launch a new operation each time OCIOSO is re-entered.
REQ-023 quociente, resto, div_zero SHALL hold their values between completions; they SHALL NOT change during CALCULA.
REQ-024 Changes on a, b after the accepted start edge SHALL NOT affect the result.

Reset
REQ-025 rst=1 SHALL force OCIOSO, busy=0, done=0, quociente=0, resto=0, div_zero=0 immediately, independent of clk.
REQ-026 rst asserted during CALCULA SHALL abort the operation; no done pulse SHALL follow release.
REQ-027 First start after rst release SHALL be accepted on the first rising edge with rst low.

Structure
REQ-028 Shared package SHALL hold the state enumeration (OCIOSO, CALCULA, FIM) and the default width constants.
REQ-029 One combinational sub-module, passo_divisao, SHALL implement a single trial-subtract/restore step, parametrised by LARGURA_B.
REQ-030 Counter width SHALL be derived as ceil(log2(LARGURA_A+1)).

Verification
REQ-031 Defaults, a=200, b=7, start 1 cycle -> done 8 cycles later, quociente=28, resto=4, div_zero=0.
REQ-032 Defaults, a=5, b=0 -> done next cycle, quociente=0, resto=0, div_zero=1; following a=255, b=1 -> quociente=255, resto=0, div_zero=0.
REQ-033 Defaults, a=3, b=15 -> quociente=0, resto=3; a=255, b=15 -> quociente=17, resto=0.
REQ-034 Defaults, a=100, b=9 started, second start with a=50, b=5 at cycle 3 -> ignored, result quociente=11, resto=1, one done pulse.
REQ-035 Defaults, rst pulsed at cycle 4 of CALCULA -> all outputs 0 at once, no done; next start a=17, b=4 -> quociente=4, resto=1.
REQ-036 LARGURA_A=5, LARGURA_B=4, a=31, b=4 -> done 5 cycles after start, quociente=7, resto=3; exhaustive sweep of all a, b matches a/b, a%b.

Source files
------------

// File: rtl/divisao_sequencial_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package divisao_sequencial_pkg;

    localparam int LARGURA_A_PADRAO = 8;
    localparam int LARGURA_B_PADRAO = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        FIM     = 2'd2
    } estado_t;

    // Bits needed to hold the step count, which runs from LARGURA_A down to 1.
    function automatic int largura_contador(input int largura);
        return $clog2(largura + 1);
    endfunction

endpackage

// File: rtl/divisao_sequencial_passo.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
module passo_divisao #(
    parameter int LARGURA_B = 4
) (
    input  logic [LARGURA_B:0]   resto_parcial,
    input  logic                 bit_entrada,
    input  logic [LARGURA_B-1:0] divisor,
    output logic [LARGURA_B:0]   resto_novo,
    output logic                 bit_quociente
);

    logic [LARGURA_B+1:0] deslocado_s;
    logic [LARGURA_B:0]   diferenca_s;

    // The shifted remainder is below 2*divisor, so LARGURA_B+1 bits always hold the result.
    always_comb begin
        deslocado_s = {resto_parcial, bit_entrada};
        diferenca_s = deslocado_s[LARGURA_B:0] - {1'b0, divisor};
        if (deslocado_s >= {2'b00, divisor}) begin
            bit_quociente = 1'b1;
            resto_novo    = diferenca_s;
        end else begin
            bit_quociente = 1'b0;
            resto_novo    = deslocado_s[LARGURA_B:0];
        end
    end

endmodule

// File: rtl/divisao_sequencial.sv
// Sequential unsigned divider: one quotient bit per clock, results held until the next completion.
module divisao_sequencial
    import divisao_sequencial_pkg::*;
#(
    parameter int LARGURA_A = LARGURA_A_PADRAO,
    parameter int LARGURA_B = LARGURA_B_PADRAO
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LARGURA_A-1:0] a,
    input  logic [LARGURA_B-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [LARGURA_A-1:0] quociente,
    output logic [LARGURA_B-1:0] resto,
    output logic                 div_zero
);

    localparam int LARGURA_CONT = largura_contador(LARGURA_A);

    estado_t                 estado_q,    estado_d;
    logic [LARGURA_A-1:0]    dividendo_q, dividendo_d;
    logic [LARGURA_B-1:0]    divisor_q,   divisor_d;
    logic [LARGURA_B:0]      parcial_q,   parcial_d;
    logic [LARGURA_CONT-1:0] cont_q,      cont_d;
    logic [LARGURA_A-1:0]    quociente_q, quociente_d;
    logic [LARGURA_B-1:0]    resto_q,     resto_d;
    logic                    div_zero_q,  div_zero_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    logic [LARGURA_B:0]      passo_resto_s;
    logic                    passo_bit_s;
    logic [LARGURA_A-1:0]    dividendo_desl_s;

    passo_divisao #(
        .LARGURA_B (LARGURA_B)
    ) u_passo (
        .resto_parcial (parcial_q),
        .bit_entrada   (dividendo_q[LARGURA_A-1]),
        .divisor       (divisor_q),
        .resto_novo    (passo_resto_s),
        .bit_quociente (passo_bit_s)
    );

    // The dividend register doubles as the quotient accumulator: bits leave at the top, enter at the bottom.
    assign dividendo_desl_s = {dividendo_q[LARGURA_A-2:0], passo_bit_s};

    // Next-state and datapath updates for all registers.
    always_comb begin
        estado_d    = estado_q;
        dividendo_d = dividendo_q;
        divisor_d   = divisor_q;
        parcial_d   = parcial_q;
        cont_d      = cont_q;
        quociente_d = quociente_q;
        resto_d     = resto_q;
        div_zero_d  = div_zero_q;
        case (estado_q)
            OCIOSO: begin
                if (start) begin
                    if (b != {LARGURA_B{1'b0}}) begin
                        dividendo_d = a;
                        divisor_d   = b;
                        parcial_d   = {(LARGURA_B+1){1'b0}};
                        cont_d      = LARGURA_CONT'(LARGURA_A);
                        estado_d    = CALCULA;
                    end else begin
                        quociente_d = {LARGURA_A{1'b0}};
                        resto_d     = {LARGURA_B{1'b0}};
                        div_zero_d  = 1'b1;
                        estado_d    = FIM;
                    end
                end else begin
                    estado_d = OCIOSO;
                end
            end
            CALCULA: begin
                dividendo_d = dividendo_desl_s;
                parcial_d   = passo_resto_s;
                cont_d      = cont_q - LARGURA_CONT'(1);
                if (cont_q == LARGURA_CONT'(1)) begin
                    quociente_d = dividendo_desl_s;
                    resto_d     = passo_resto_s[LARGURA_B-1:0];
                    div_zero_d  = 1'b0;
                    estado_d    = FIM;
                end else begin
                    estado_d = CALCULA;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
        busy_d = (estado_d != OCIOSO);
        done_d = (estado_d == FIM);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q    <= OCIOSO;
            dividendo_q <= {LARGURA_A{1'b0}};
            divisor_q   <= {LARGURA_B{1'b0}};
            parcial_q   <= {(LARGURA_B+1){1'b0}};
            cont_q      <= {LARGURA_CONT{1'b0}};
            quociente_q <= {LARGURA_A{1'b0}};
            resto_q     <= {LARGURA_B{1'b0}};
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            dividendo_q <= dividendo_d;
            divisor_q   <= divisor_d;
            parcial_q   <= parcial_d;
            cont_q      <= cont_d;
            quociente_q <= quociente_d;
            resto_q     <= resto_d;
            div_zero_q  <= div_zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quociente = quociente_q;
    assign resto     = resto_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_divisao_sequencial.sv
// Scoreboard bench for divisao_sequencial: default 8/4 instance plus a 5/4 instance swept exhaustively.
module tb_divisao_sequencial;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } esperado_t;

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vetor_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start0 = 1'b0;
    logic [7:0] a0 = 8'd0;
    logic [3:0] b0 = 4'd0;
    logic       busy0, done0, dz0;
    logic [7:0] quo0;
    logic [3:0] resto0;

    logic       start1 = 1'b0;
    logic [4:0] a1 = 5'd0;
    logic [3:0] b1 = 4'd0;
    logic       busy1, done1, dz1;
    logic [4:0] quo1;
    logic [3:0] resto1;

    int total = 0;
    int bad   = 0;
    int dones0 = 0;
    logic [7:0] ult_q0 = 8'd0;

    esperado_t sb0[$];
    esperado_t sb1[$];

    always #5 clk = ~clk;

    divisao_sequencial u_dut0 (
        .clk (clk), .rst (rst), .start (start0), .a (a0), .b (b0),
        .busy (busy0), .done (done0), .quociente (quo0), .resto (resto0), .div_zero (dz0)
    );

    divisao_sequencial #(.LARGURA_A(5), .LARGURA_B(4)) u_dut1 (
        .clk (clk), .rst (rst), .start (start1), .a (a1), .b (b1),
        .busy (busy1), .done (done1), .quociente (quo1), .resto (resto1), .div_zero (dz1)
    );

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", nome, got, exp, $time);
        end
    endtask

    // Pop and compare the default instance's result on every done pulse.
    always @(negedge clk) begin : mon0
        esperado_t e;
        if (done0) begin
            dones0++;
            if (sb0.size() == 0) begin
                chk("done0_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb0.pop_front();
                chk("quociente0", quo0, e.q);
                chk("resto0", resto0, e.r);
                chk("div_zero0", dz0, e.dz);
            end
        end
    end

    // Pop and compare the narrow instance's result on every done pulse.
    always @(negedge clk) begin : mon1
        esperado_t e;
        if (done1) begin
            if (sb1.size() == 0) begin
                chk("done1_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb1.pop_front();
                chk("quociente1", quo1, e.q);
                chk("resto1", resto1, e.r);
                chk("div_zero1", dz1, e.dz);
            end
        end
    end

    task automatic op0(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input logic edz);
        int n;
        int lat;
        lat = (b == 4'd0) ? 0 : 8;
        sb0.push_back('{eq, er, edz});
        a0 = a; b0 = b; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; a0 = ~a; b0 = ~b;
        n = 0;
        while (!done0 && n < 40) begin
            chk("busy0", busy0, 32'd1);
            chk("hold_q0", quo0, ult_q0);
            @(posedge clk); #1;
            n++;
        end
        chk("latency0", n, lat);
        ult_q0 = eq;
        @(posedge clk); #1;
        chk("idle0", {30'd0, done0, busy0}, 32'd0);
    endtask

    task automatic op1(input logic [4:0] a, input logic [3:0] b);
        int n;
        int lat;
        esperado_t e;
        if (b == 4'd0) begin
            e = '{8'd0, 4'd0, 1'b1};
            lat = 0;
        end else begin
            e = '{8'(a / b), 4'(a % b), 1'b0};
            lat = 5;
        end
        sb1.push_back(e);
        a1 = a; b1 = b; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency1", n, lat);
        @(posedge clk); #1;
    endtask

    // Watchdog: a hung run still reports before stopping.
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vetor_t tabela[10];
        int n;
        int d0;
        tabela[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0};
        tabela[1] = '{8'd5,   4'd0,  8'd0,   4'd0, 1'b1};
        tabela[2] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0};
        tabela[3] = '{8'd3,   4'd15, 8'd0,   4'd3, 1'b0};
        tabela[4] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0};
        tabela[5] = '{8'd0,   4'd5,  8'd0,   4'd0, 1'b0};
        tabela[6] = '{8'd128, 4'd3,  8'd42,  4'd2, 1'b0};
        tabela[7] = '{8'd77,  4'd8,  8'd9,   4'd5, 1'b0};
        tabela[8] = '{8'd1,   4'd1,  8'd1,   4'd0, 1'b0};
        tabela[9] = '{8'd0,   4'd0,  8'd0,   4'd0, 1'b1};

        #1;
        chk("reset_outputs0", {busy0, done0, dz0, quo0, resto0}, 32'd0);
        chk("reset_outputs1", {busy1, done1, dz1, quo1, resto1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            op0(tabela[i].a, tabela[i].b, tabela[i].q, tabela[i].r, tabela[i].dz);
        end

        // Start held high with b=0: a new operation each time the idle state is re-entered.
        sb0.push_back('{8'd0, 8'd0, 1'b1});
        sb0.push_back('{8'd0, 8'd0, 1'b1});
        a0 = 8'd9; b0 = 4'd0; start0 = 1'b1;
        n = 0;
        d0 = 0;
        while (d0 < 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done0) d0++;
        end
        start0 = 1'b0;
        chk("held_start_cycles", n, 32'd3);
        ult_q0 = 8'd0;
        repeat (2) @(posedge clk);
        #1;

        // Second start during the calculation is ignored.
        sb0.push_back('{8'd11, 4'd1, 1'b0});
        d0 = dones0;
        a0 = 8'd100; b0 = 4'd9; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a0 = 8'd50; b0 = 4'd5; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 3;
        while (!done0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency_ignored_start", n, 32'd8);
        repeat (12) @(posedge clk);
        #1;
        chk("single_done", dones0 - d0, 32'd1);

        // Reset in the middle of a calculation aborts it.
        a0 = 8'd100; b0 = 4'd9; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_outputs", {busy0, done0, dz0, quo0, resto0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ult_q0 = 8'd0;
        d0 = dones0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_abort", dones0 - d0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op0(8'd17, 4'd4, 8'd4, 4'd1, 1'b0);

        // Narrow instance: the named case first, then every a, b pair.
        op1(5'd31, 4'd4);
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 16; b++) begin
                op1(5'(a), 4'(b));
            end
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb0_drained", sb0.size(), 32'd0);
        chk("sb1_drained", sb1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
